// File: rtl/memory_pkg.sv
// Shared types and constants for the memory pipeline stage.
package memory_pkg;

    localparam int DATA_W = 24;
    localparam int REG_AW = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    // Control fields carried in the EX/MEM register.
    typedef struct packed {
        logic              pc_src;
        logic              reg_write;
        logic              mem_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] wa3;
    } exm_ctrl_t;

    localparam exm_ctrl_t EXM_BUBBLE = '0;

endpackage

// File: rtl/memory_stage_fsm.sv
// Data-memory req/ready handshake with a bounded wait counter.
module dmem_handshake_fsm #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_op,
    input  logic dmem_ready,
    output logic dmem_req,
    output logic complete,
    output logic timeout
);
    import memory_pkg::*;

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    mem_state_t state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // State and wait-count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next state and handshake outputs; the request is raised in the same
    // cycle the op appears so a ready memory completes with zero wait.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        dmem_req   = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        complete = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = 8'd1;
                    end
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    complete   = 1'b1;
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == MAX_CNT) begin
                    // Give up: report completion so the pipeline drains.
                    timeout    = 1'b1;
                    complete   = 1'b1;
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// M stage: EX/MEM register, data-memory access, MEM/WB register.
module memory_stage #(
    parameter int DATA_W   = memory_pkg::DATA_W,
    parameter int REG_AW   = memory_pkg::REG_AW,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_result_e,
    input  logic [DATA_W-1:0] write_data_e,
    input  logic [REG_AW-1:0] wa3_e,
    input  logic              pc_src_m_in,
    input  logic              reg_write_m_in,
    input  logic              mem_write_m_in,
    input  logic              mem_to_reg_e,
    input  logic              flush_m,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [DATA_W-1:0] alu_result_memory,
    output logic              reg_write_mem,
    output logic [REG_AW-1:0] wa3_m,
    output logic              stall_mem,
    output logic              mem_error,
    output logic [DATA_W-1:0] read_data_w,
    output logic [DATA_W-1:0] alu_result_w,
    output logic [REG_AW-1:0] wa3_w,
    output logic              reg_write_w,
    output logic              mem_to_reg_w,
    output logic              pc_src_w
);
    import memory_pkg::*;

    exm_ctrl_t         ctrl_q, ctrl_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [DATA_W-1:0] rdata_w_q, rdata_w_d;
    logic [DATA_W-1:0] alu_w_q, alu_w_d;
    logic [REG_AW-1:0] wa3_w_q, wa3_w_d;
    logic              rw_w_q, rw_w_d;
    logic              m2r_w_q, m2r_w_d;
    logic              pcs_w_q, pcs_w_d;
    logic              mem_error_q, mem_error_d;

    logic is_load, mem_op, complete, timeout;

    assign is_load = ctrl_q.mem_to_reg & ctrl_q.reg_write;
    assign mem_op  = ctrl_q.mem_write | is_load;

    dmem_handshake_fsm #(.MAX_WAIT(MAX_WAIT)) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_op     (mem_op),
        .dmem_ready (dmem_ready),
        .dmem_req   (dmem_req),
        .complete   (complete),
        .timeout    (timeout)
    );

    assign stall_mem         = mem_op & ~complete;
    assign dmem_we           = ctrl_q.mem_write;
    assign dmem_addr         = alu_q;
    assign dmem_wdata        = wdata_q;
    assign alu_result_memory = alu_q;
    assign reg_write_mem     = ctrl_q.reg_write;
    assign wa3_m             = ctrl_q.wa3;

    assign read_data_w  = rdata_w_q;
    assign alu_result_w = alu_w_q;
    assign wa3_w        = wa3_w_q;
    assign reg_write_w  = rw_w_q;
    assign mem_to_reg_w = m2r_w_q;
    assign pc_src_w     = pcs_w_q;
    assign mem_error    = mem_error_q;

    // EX/MEM next value: hold on stall (beats flush), bubble on flush, else capture.
    always_comb begin
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;
        wdata_d = wdata_q;
        if (!stall_mem) begin
            if (flush_m) begin
                ctrl_d  = EXM_BUBBLE;
                alu_d   = '0;
                wdata_d = '0;
            end else begin
                ctrl_d.pc_src     = pc_src_m_in;
                ctrl_d.reg_write  = reg_write_m_in;
                ctrl_d.mem_write  = mem_write_m_in;
                ctrl_d.mem_to_reg = mem_to_reg_e;
                ctrl_d.wa3        = wa3_e;
                alu_d             = alu_result_e;
                wdata_d           = write_data_e;
            end
        end
    end

    // MEM/WB next value: bubble while the access is incomplete so write-back
    // commits each instruction exactly once.
    always_comb begin
        rdata_w_d   = '0;
        alu_w_d     = '0;
        wa3_w_d     = '0;
        rw_w_d      = 1'b0;
        m2r_w_d     = 1'b0;
        pcs_w_d     = 1'b0;
        mem_error_d = mem_error_q | timeout;
        if (!stall_mem) begin
            rdata_w_d = (is_load && !timeout) ? dmem_rdata : '0;
            alu_w_d   = alu_q;
            wa3_w_d   = ctrl_q.wa3;
            rw_w_d    = ctrl_q.reg_write;
            m2r_w_d   = ctrl_q.mem_to_reg;
            pcs_w_d   = ctrl_q.pc_src;
        end
    end

    // Pipeline registers and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q      <= EXM_BUBBLE;
            alu_q       <= '0;
            wdata_q     <= '0;
            rdata_w_q   <= '0;
            alu_w_q     <= '0;
            wa3_w_q     <= '0;
            rw_w_q      <= 1'b0;
            m2r_w_q     <= 1'b0;
            pcs_w_q     <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            alu_q       <= alu_d;
            wdata_q     <= wdata_d;
            rdata_w_q   <= rdata_w_d;
            alu_w_q     <= alu_w_d;
            wa3_w_q     <= wa3_w_d;
            rw_w_q      <= rw_w_d;
            m2r_w_q     <= m2r_w_d;
            pcs_w_q     <= pcs_w_d;
            mem_error_q <= mem_error_d;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage (MAX_WAIT=4).
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] alu_result_e, write_data_e, dmem_rdata;
    logic [3:0]  wa3_e;
    logic        pc_src_m_in, reg_write_m_in, mem_write_m_in, mem_to_reg_e, flush_m, dmem_ready;
    logic        dmem_req, dmem_we, reg_write_mem, stall_mem, mem_error;
    logic        reg_write_w, mem_to_reg_w, pc_src_w;
    logic [23:0] dmem_addr, dmem_wdata, alu_result_memory, read_data_w, alu_result_w;
    logic [3:0]  wa3_m, wa3_w;

    int total = 0;
    int bad   = 0;
    int writes;

    memory_stage #(.DATA_W(24), .REG_AW(4), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e), .wa3_e(wa3_e),
        .pc_src_m_in(pc_src_m_in), .reg_write_m_in(reg_write_m_in),
        .mem_write_m_in(mem_write_m_in), .mem_to_reg_e(mem_to_reg_e), .flush_m(flush_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .alu_result_memory(alu_result_memory), .reg_write_mem(reg_write_mem),
        .wa3_m(wa3_m), .stall_mem(stall_mem), .mem_error(mem_error),
        .read_data_w(read_data_w), .alu_result_w(alu_result_w), .wa3_w(wa3_w),
        .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w), .pc_src_w(pc_src_w)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] alu; logic [23:0] wd; logic [3:0] wa3;
        logic rw; logic mw; logic m2r; logic fl; logic rdy; logic [23:0] rd;
        logic req; logic stall; logic rwm; logic [23:0] alum;   // before the edge
        logic rww; logic [3:0] wa3w; logic [23:0] rdw;          // after the edge
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [23:0] alu, input logic [23:0] wd, input logic [3:0] wa3,
                         input logic rw, input logic mw, input logic m2r, input logic pcs,
                         input logic fl, input logic rdy, input logic [23:0] rd);
        alu_result_e = alu; write_data_e = wd; wa3_e = wa3;
        reg_write_m_in = rw; mem_write_m_in = mw; mem_to_reg_e = m2r; pc_src_m_in = pcs;
        flush_m = fl; dmem_ready = rdy; dmem_rdata = rd;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic rdy, input logic [23:0] rd);
        drive(24'h0, 24'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy, rd);
    endtask

    initial begin
        // alu wd wa3 rw mw m2r fl rdy rd | req stall rwm alum | rww wa3w rdw
        vt[0]  = '{24'h10, 24'h0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'hABCDEF, 1'b0, 1'b0, 1'b0, 24'h0,  1'b0, 4'd0, 24'h0};
        vt[1]  = '{24'h0,  24'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'hABCDEF, 1'b1, 1'b0, 1'b1, 24'h10, 1'b1, 4'd3, 24'hABCDEF};
        vt[2]  = '{24'h7,  24'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h0,  1'b0, 4'd0, 24'h0};
        vt[3]  = '{24'h30, 24'h0, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24'h111111, 1'b0, 1'b0, 1'b1, 24'h7,  1'b1, 4'd5, 24'h0};
        vt[4]  = '{24'h0,  24'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h222222, 1'b1, 1'b0, 1'b1, 24'h30, 1'b1, 4'd6, 24'h222222};
        vt[5]  = '{24'h99, 24'h0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h0,  1'b0, 4'd0, 24'h0};
        vt[6]  = '{24'h0,  24'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h0,  1'b0, 4'd0, 24'h0};
        vt[7]  = '{24'h40, 24'h0, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h0,  1'b0, 4'd0, 24'h0};
        vt[8]  = '{24'h0,  24'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0,      1'b1, 1'b1, 1'b1, 24'h40, 1'b0, 4'd0, 24'h0};
        vt[9]  = '{24'h0,  24'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h333333, 1'b1, 1'b0, 1'b1, 24'h40, 1'b1, 4'd7, 24'h333333};
        vt[10] = '{24'h0,  24'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 24'h0,  1'b0, 4'd0, 24'h0};

        // Reset with random inputs.
        rst = 1'b1;
        drive(24'($urandom), 24'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom));
        edge1();
        edge1();
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_stall", {31'b0, stall_mem}, 32'd0);
        chk("rst_err", {31'b0, mem_error}, 32'd0);
        chk("rst_outs", {8'b0, dmem_we, reg_write_mem, reg_write_w, mem_to_reg_w, pc_src_w, wa3_m, wa3_w, 7'b0},
            32'd0);
        chk("rst_data", {8'b0, dmem_addr | dmem_wdata | alu_result_memory | read_data_w | alu_result_w}, 32'd0);
        rst = 1'b0;

        // Table: zero-wait loads, back-to-back ALU/load, flush with and without stall.
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].alu, vt[i].wd, vt[i].wa3, vt[i].rw, vt[i].mw, vt[i].m2r, 1'b0,
                  vt[i].fl, vt[i].rdy, vt[i].rd);
            #1;
            chk($sformatf("v%0d_req", i), {31'b0, dmem_req}, {31'b0, vt[i].req});
            chk($sformatf("v%0d_stall", i), {31'b0, stall_mem}, {31'b0, vt[i].stall});
            chk($sformatf("v%0d_rwm", i), {31'b0, reg_write_mem}, {31'b0, vt[i].rwm});
            chk($sformatf("v%0d_alum", i), {8'b0, alu_result_memory}, {8'b0, vt[i].alum});
            edge1();
            chk($sformatf("v%0d_rww", i), {31'b0, reg_write_w}, {31'b0, vt[i].rww});
            chk($sformatf("v%0d_wa3w", i), {28'b0, wa3_w}, {28'b0, vt[i].wa3w});
            chk($sformatf("v%0d_rdw", i), {8'b0, read_data_w}, {8'b0, vt[i].rdw});
        end

        // Three-cycle store: ready on the third request cycle.
        writes = 0;
        drive(24'h20, 24'h123456, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        edge1();
        for (int k = 0; k < 3; k++) begin
            nop(k == 2, 24'h0);
            #1;
            chk($sformatf("st%0d_req", k), {31'b0, dmem_req}, 32'd1);
            chk($sformatf("st%0d_stall", k), {31'b0, stall_mem}, {31'b0, k != 2});
            chk($sformatf("st%0d_bus", k), {7'b0, dmem_we, dmem_addr}, {7'b0, 1'b1, 24'h20});
            chk($sformatf("st%0d_wd", k), {8'b0, dmem_wdata}, {8'b0, 24'h123456});
            if (dmem_req && dmem_we && dmem_ready) writes++;
            edge1();
            chk($sformatf("st%0d_wbrw", k), {31'b0, reg_write_w}, 32'd0);
        end
        nop(1'b1, 24'h0);
        #1;
        chk("st_after_req", {31'b0, dmem_req}, 32'd0);
        chk("st_writes", writes, 32'd1);
        edge1();

        // Timeout: load never sees ready.
        drive(24'h50, 24'h0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        edge1();
        for (int k = 0; k < 5; k++) begin
            nop(1'b0, 24'hFFFFFF);
            #1;
            chk($sformatf("to%0d_req", k), {31'b0, dmem_req}, 32'd1);
            chk($sformatf("to%0d_stall", k), {31'b0, stall_mem}, {31'b0, k < 4});
            edge1();
            chk($sformatf("to%0d_err", k), {31'b0, mem_error}, {31'b0, k == 4});
        end
        chk("to_rdw", {8'b0, read_data_w}, 32'd0);
        chk("to_rww", {27'b0, reg_write_w, wa3_w}, {27'b0, 1'b1, 4'd8});
        // Pipeline resumes; error stays set.
        drive(24'h60, 24'h0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 24'h0A0B0C);
        #1;
        chk("to_after_req", {31'b0, dmem_req}, 32'd0);
        edge1();
        nop(1'b1, 24'h0A0B0C);
        #1;
        chk("rs_req", {30'b0, dmem_req, stall_mem}, {30'b0, 2'b10});
        edge1();
        chk("rs_rdw", {8'b0, read_data_w}, {8'b0, 24'h0A0B0C});
        chk("rs_ctl", {29'b0, pc_src_w, mem_to_reg_w, mem_error}, {29'b0, 3'b111});

        // Reset in the middle of an access.
        drive(24'h70, 24'h0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        edge1();
        nop(1'b0, 24'h0);
        #1;
        chk("mr_req_pre", {30'b0, dmem_req, stall_mem}, {30'b0, 2'b11});
        rst = 1'b1;
        edge1();
        chk("mr_req_post", {29'b0, dmem_req, stall_mem, mem_error}, 32'd0);
        rst = 1'b0;
        edge1();
        chk("mr_idle", {31'b0, dmem_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage: EX/MEM register, data-memory access over a variable-latency req/ready handshake, and MEM/WB register feeding write-back.
- Returns the M-stage ALU result to execute for forwarding (forward select 2'b10).
- Reports M-stage register-write info to the hazard unit.
- Stalls the front of the pipeline while a memory access is outstanding.

Parameters:
- DATA_W, 24, datapath and address width.
- REG_AW, 4, register-file address width.
- MAX_WAIT, 15, maximum cycles to wait for dmem_ready before aborting the access (range 1..255).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- alu_result_e  in  DATA_W  ALU result from execute; also the memory address.
- write_data_e  in  DATA_W  store data, already forwarded.
- wa3_e  in  REG_AW  destination register.
- pc_src_m_in, reg_write_m_in, mem_write_m_in  in  1 each  condition-gated controls from execute.
- mem_to_reg_e  in  1  load: write-back selects memory data.
- flush_m  in  1  hazard unit: load a bubble into EX/MEM.
- dmem_req  out  1  access request.
- dmem_we  out  1  write enable.
- dmem_addr  out  DATA_W  address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data.
- dmem_ready  in  1  access complete.
- alu_result_memory  out  DATA_W  M-stage ALU result, forwarded to execute.
- reg_write_mem  out  1  M-stage reg_write, to hazard unit.
- wa3_m  out  REG_AW  M-stage destination, to hazard unit.
- stall_mem  out  1  freeze F/D/E and EX/MEM.
- mem_error  out  1  sticky timeout flag.
- read_data_w, alu_result_w  out  DATA_W each  to write-back.
- wa3_w  out  REG_AW  to write-back.
- reg_write_w, mem_to_reg_w, pc_src_w  out  1 each  to write-back.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All EX/MEM and MEM/WB registers, counter and mem_error go to 0; FSM goes to IDLE.
  - Consequently every output is 0, including stall_mem and dmem_req.
- EX/MEM register update at each edge:
  - stall_mem=1: hold current contents (stall has priority; flush_m is ignored).
  - Else flush_m=1: load a bubble (all controls 0, data 0).
  - Else: capture the E-stage inputs.
- mem_op: a memory access is pending when the M-stage holds a store (mem_write_m=1) or a load (mem_to_reg_m=1 and reg_write_m=1).
- FSM (sub-module), states IDLE and WAIT:
  - IDLE with mem_op: dmem_req=1 combinationally that same cycle.
    - dmem_ready=1 in that cycle: access completes, zero-wait.
    - dmem_ready=0: go to WAIT, wait_cnt=1.
  - WAIT: dmem_req=1.
    - dmem_ready=1: complete; go to IDLE.
    - wait_cnt==MAX_WAIT without dmem_ready: abort. Set mem_error, treat as complete with read data 0, go to IDLE.
    - Otherwise wait_cnt increments.
  - dmem_addr, dmem_we and dmem_wdata come straight from EX/MEM and are stable while dmem_req=1, because EX/MEM is held.
  - dmem_ready is ignored whenever dmem_req=0.
- stall_mem = mem_op & ~complete_this_cycle (combinational).
  - A zero-wait access never stalls.
  - An N-cycle access stalls N-1 cycles.
  - Exactly one request is issued per instruction.
- MEM/WB register at each edge:
  - stall_mem=1: load a bubble (reg_write_w=0, pc_src_w=0) so write-back never repeats or commits an incomplete op.
  - Else: capture the M-stage fields, with read_data_w = dmem_rdata (0 on abort or non-load).
- Pass-through: alu_result_memory = EX/MEM ALU result and is valid during stalls.
- mem_error clears only on rst.
- rst mid-access: dmem_req drops in the cycle after the reset edge; the in-flight access is abandoned.

Decomposition:
- Shared package memory_pkg:
  - DATA_W=24 and REG_AW=4 constants.
  - mem_state_t enum {IDLE, WAIT}.
  - Control struct for EX/MEM (pc_src, reg_write, mem_write, mem_to_reg, wa3).
  - Bubble constant, all zero.
- One sub-module dmem_handshake_fsm: inputs mem_op and dmem_ready; outputs dmem_req, complete, timeout; contains the wait counter.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> all outputs 0; state IDLE.
- Zero-wait load: alu_result_e=24'h000010, mem_to_reg=1, reg_write=1, wa3=3; dmem_ready tied 1, rdata=24'hABCDEF -> dmem_req for 1 cycle, stall_mem never 1; next cycle read_data_w=24'hABCDEF, wa3_w=3, reg_write_w=1.
- 3-cycle store: mem_write=1, addr 24'h000020, wdata 24'h123456; ready on the 3rd req cycle -> stall_mem=1 for 2 cycles; addr/wdata/we stable; MEM/WB bubbles 2 cycles; one write observed.
- Timeout with MAX_WAIT=4: load with ready never high -> stall lasts 4 cycles; mem_error=1 and stays 1; read_data_w=0; pipeline resumes.
- Flush vs stall: flush_m=1 while no stall -> next M stage is a bubble (reg_write_mem=0, dmem_req=0); flush_m=1 during a stall -> ignored, op completes.
- Back-to-back: ALU op (reg_write, wa3=5, result 24'h000007) then load -> alu_result_memory=24'h000007 and reg_write_mem=1 in the M cycle; the load then issues with no extra gap.
